// File: rtl/pc_sequencer.sv
// Program-counter register stage: holds the fetch PC, applies redirects from pc_datapath,
// keeps a call/return address stack and a halt/resume control FSM.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  STACK_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fetch_ready,
  input  logic                             pc_overwrite,
  input  logic [PC_WIDTH-1:0]              overwrite_data,
  input  logic                             is_call,
  input  logic                             is_return,
  input  logic                             halt,
  input  logic                             resume,
  output logic [PC_WIDTH-1:0]              pc_mux,
  output logic                             fetch_valid,
  output logic                             halted,
  output logic [$clog2(STACK_DEPTH):0]     stack_count,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALTED} state_t;

  state_t              r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next;
  logic [CW-1:0]       r_count, w_count_next;
  logic                r_ovf, r_unf;
  logic                w_push, w_set_ovf, w_set_unf;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [IW-1:0]       w_push_idx, w_top_idx;
  logic [PC_WIDTH-1:0] w_ret_addr;
  logic                w_empty, w_full;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(STACK_DEPTH));
  assign w_push_idx = r_count[IW-1:0];
  // When full the low bits wrap to 0, so subtracting one still lands on the top entry.
  assign w_top_idx  = w_push_idx - IW'(1);
  assign w_ret_addr = r_pc + PC_WIDTH'(1);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_push       = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    case (r_state)
      S_BOOT: w_state_next = S_RUN;
      S_RUN, S_FLUSH: begin
        if (halt) begin
          w_state_next = S_HALTED;
        end else if (is_return) begin
          if (w_empty) begin
            w_set_unf    = 1'b1;
            w_state_next = S_HALTED;
          end else begin
            w_pc_next    = r_stack[w_top_idx];
            w_count_next = r_count - CW'(1);
            w_state_next = S_FLUSH;
          end
        end else if (pc_overwrite) begin
          if (is_call && w_full) begin
            w_set_ovf    = 1'b1;
            w_state_next = S_HALTED;
          end else begin
            w_pc_next    = overwrite_data;
            w_state_next = S_FLUSH;
            if (is_call) begin
              w_push       = 1'b1;
              w_count_next = r_count + CW'(1);
            end
          end
        end else if (r_state == S_RUN) begin
          if (fetch_ready) w_pc_next = r_pc + PC_WIDTH'(1);
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_HALTED: begin
        if (!halt && resume && !r_ovf && !r_unf) w_state_next = S_RUN;
      end
      default: w_state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (w_push && (w_push_idx == IW'(i))) r_stack[i] <= w_ret_addr;
      end
    end
  end

  assign pc_mux          = r_pc;
  assign fetch_valid     = (r_state == S_RUN);
  assign halted          = (r_state == S_HALTED);
  assign stack_count     = r_count;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus, a queue-based reference model checked every
// cycle, and literal expectations from hand-traced sequences.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fetch_ready = 1'b0;
  logic       pc_overwrite = 1'b0;
  logic [7:0] overwrite_data = 8'h00;
  logic       is_call = 1'b0;
  logic       is_return = 1'b0;
  logic       halt = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] pc_mux;
  logic       fetch_valid;
  logic       halted;
  logic [2:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  pc_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(8'h00), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .pc_overwrite(pc_overwrite), .overwrite_data(overwrite_data),
    .is_call(is_call), .is_return(is_return), .halt(halt), .resume(resume),
    .pc_mux(pc_mux), .fetch_valid(fetch_valid), .halted(halted),
    .stack_count(stack_count), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: modes as named ints, return stack as a queue.
  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;
  int         m_mode = M_BOOT;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_stk [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_BOOT; m_pc = 8'h00; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (resume && !halt && !m_ovf && !m_unf) m_mode = M_RUN;
    end else if (halt) begin
      m_mode = M_HALT;
    end else if (is_return) begin
      if (m_stk.size() == 0) begin
        m_unf = 1'b1; m_mode = M_HALT;
      end else begin
        m_pc = m_stk.pop_back(); m_mode = M_FLUSH;
      end
    end else if (pc_overwrite) begin
      if (is_call && m_stk.size() == 4) begin
        m_ovf = 1'b1; m_mode = M_HALT;
      end else begin
        if (is_call) m_stk.push_back(m_pc + 8'h01);
        m_pc = overwrite_data; m_mode = M_FLUSH;
      end
    end else if (m_mode == M_RUN) begin
      if (fetch_ready) m_pc = m_pc + 8'h01;
    end else begin
      m_mode = M_RUN;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (cmp_on) begin
      chk("model_pc", 32'(pc_mux), 32'(m_pc));
      chk("model_fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
      chk("model_halted", 32'(halted), 32'(m_mode == M_HALT));
      chk("model_stack_count", 32'(stack_count), 32'(m_stk.size()));
      chk("model_overflow", 32'(stack_overflow), 32'(m_ovf));
      chk("model_underflow", 32'(stack_underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic fr, input logic ow, input logic [7:0] od,
                       input logic call, input logic ret, input logic h, input logic res);
    fetch_ready = fr; pc_overwrite = ow; overwrite_data = od;
    is_call = call; is_return = ret; halt = h; resume = res;
  endtask

  task automatic lit_pc(input string name, input logic [7:0] exp_pc, input logic exp_fv);
    chk({name, "_pc"}, 32'(pc_mux), 32'(exp_pc));
    chk({name, "_fv"}, 32'(fetch_valid), 32'(exp_fv));
  endtask

  initial begin
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    cyc(2);
    cmp_on = 1'b1;
    lit_pc("reset", 8'h00, 1'b0);
    chk("reset_count", 32'(stack_count), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    // Boot, then free-running advance
    rst_n = 1'b1;
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    lit_pc("boot", 8'h00, 1'b0);
    cyc(); lit_pc("run0", 8'h00, 1'b1);
    cyc(); lit_pc("run1", 8'h01, 1'b1);
    cyc(); lit_pc("run2", 8'h02, 1'b1);

    // Jump to FE and wrap
    drive(1, 1, 8'hFE, 0, 0, 0, 0); cyc(); lit_pc("jfe", 8'hFE, 1'b0);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("fe", 8'hFE, 1'b1);
    cyc(); lit_pc("ff", 8'hFF, 1'b1);
    cyc(); lit_pc("wrap", 8'h00, 1'b1);

    // Stall at 10
    drive(1, 1, 8'h10, 0, 0, 0, 0); cyc();
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("at10", 8'h10, 1'b1);
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); lit_pc("stall", 8'h10, 1'b1);
    end
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("unstall", 8'h11, 1'b1);
    cyc(); lit_pc("at12", 8'h12, 1'b1);

    // Jump at 12 to 40
    drive(1, 1, 8'h40, 0, 0, 0, 0); cyc(); lit_pc("j40", 8'h40, 1'b0);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("r40", 8'h40, 1'b1);
    cyc(); lit_pc("r41", 8'h41, 1'b1);

    // Call from 20 to 80, return at 85
    drive(1, 1, 8'h20, 0, 0, 0, 0); cyc();
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("at20", 8'h20, 1'b1);
    drive(1, 1, 8'h80, 1, 0, 0, 0); cyc(); lit_pc("call80", 8'h80, 1'b0);
    chk("call_count", 32'(stack_count), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); cyc(5); lit_pc("at85", 8'h85, 1'b1);
    drive(1, 0, 8'h00, 0, 1, 0, 0); cyc(); lit_pc("ret21", 8'h21, 1'b0);
    chk("ret_count", 32'(stack_count), 32'd0);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("run21", 8'h21, 1'b1);
    cyc(); lit_pc("run22", 8'h22, 1'b1);

    // Four nested calls, fifth overflows
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'(8'h30 + 16 * k), 1, 0, 0, 0); cyc();
    end
    chk("full_count", 32'(stack_count), 32'd4);
    drive(1, 1, 8'h90, 1, 0, 0, 0); cyc();
    lit_pc("ovf", 8'h60, 1'b0);
    chk("ovf_flag", 32'(stack_overflow), 32'd1);
    chk("ovf_halted", 32'(halted), 32'd1);
    chk("ovf_count", 32'(stack_count), 32'd4);
    drive(1, 0, 8'h00, 0, 0, 0, 1); cyc();
    chk("ovf_resume_ignored", 32'(halted), 32'd1);
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    lit_pc("rst_mid", 8'h00, 1'b0);
    chk("rst_mid_ovf", 32'(stack_overflow), 32'd0);
    chk("rst_mid_count", 32'(stack_count), 32'd0);
    chk("rst_mid_halted", 32'(halted), 32'd0);
    cyc(); rst_n = 1'b1;
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("reboot", 8'h00, 1'b1);

    // Return with empty stack
    drive(1, 0, 8'h00, 0, 1, 0, 0); cyc();
    lit_pc("unf", 8'h00, 1'b0);
    chk("unf_flag", 32'(stack_underflow), 32'd1);
    chk("unf_halted", 32'(halted), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 0, 1); cyc();
    chk("unf_resume_ignored", 32'(halted), 32'd1);
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    chk("rst_unf", 32'(stack_underflow), 32'd0);
    cyc(); rst_n = 1'b1;
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); cyc(); lit_pc("at01", 8'h01, 1'b1);

    // Halt beats overwrite; halt beats resume; resume restarts at held pc
    drive(1, 1, 8'h77, 0, 0, 1, 0); cyc(); lit_pc("halt", 8'h01, 1'b0);
    chk("halt_halted", 32'(halted), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 1, 1); cyc(); chk("halt_wins", 32'(halted), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 0, 1); cyc(); lit_pc("resumed", 8'h01, 1'b1);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("after_resume", 8'h02, 1'b1);

    // Nested calls and returns, second return taken during FLUSH
    drive(1, 1, 8'hA0, 1, 0, 0, 0); cyc(); lit_pc("callA0", 8'hA0, 1'b0);
    drive(1, 1, 8'hB0, 1, 0, 0, 0); cyc(); lit_pc("callB0", 8'hB0, 1'b0);
    chk("nest_count", 32'(stack_count), 32'd2);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("runB0", 8'hB0, 1'b1);
    drive(1, 0, 8'h00, 0, 1, 0, 0); cyc(); lit_pc("retA1", 8'hA1, 1'b0);
    cyc(); lit_pc("ret03", 8'h03, 1'b0);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(); lit_pc("run03", 8'h03, 1'b1);
    drive(1, 0, 8'h00, 1, 0, 0, 0); cyc(); lit_pc("lone_call", 8'h04, 1'b1);
    chk("lone_call_count", 32'(stack_count), 32'd0);
    drive(1, 0, 8'h00, 0, 0, 0, 0); cyc(2);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register stage that sits directly downstream of pc_datapath.
- Consumes pc_datapath's jump/branch target (overwrite_data) and its redirect strobe (pc_overwrite).
- Holds the current PC and drives it back as pc_mux, which feeds both pc_datapath and instruction fetch.
- Adds a fetch valid/ready handshake, a one-cycle flush bubble after every redirect, a call/return address stack, and halt/resume control.

Parameters:
- PC_WIDTH, 8: width of PC, targets and stack entries.
- RESET_VECTOR, 8'h00: PC value loaded on reset.
- STACK_DEPTH, 4: number of return-address entries; must be a power of 2, 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_ready  input  1  fetch accepts the current PC this cycle.
- pc_overwrite  input  1  taken jump/branch; load overwrite_data.
- overwrite_data  input  PC_WIDTH  redirect target from pc_datapath.
- is_call  input  1  with pc_overwrite: push the return address.
- is_return  input  1  pop the stack and redirect to the popped value.
- halt  input  1  enter HALTED.
- resume  input  1  leave HALTED; ignored while any error flag is set.
- pc_mux  output  PC_WIDTH  current PC.
- fetch_valid  output  1  pc_mux is a valid fetch address.
- halted  output  1  state == HALTED.
- stack_count  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_overflow  output  1  sticky error flag; cleared only by reset.
- stack_underflow  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=BOOT, stack_count=0.
  - Both error flags 0; fetch_valid=0; halted=0.
- States: BOOT, RUN, FLUSH, HALTED. All outputs are registered or decoded from state only.
- fetch_valid is 1 only in RUN.
- BOOT: lasts exactly one cycle after reset deassertion, then RUN. All inputs are ignored in BOOT.
- Event priority each cycle in RUN or FLUSH, highest first:
  1. halt -> HALTED; PC holds; stack unchanged.
  2. is_return:
     - Stack non-empty: pc <= top entry, stack_count-1, state FLUSH.
     - Stack empty: stack_underflow <= 1, state HALTED, PC holds.
     - is_call in the same cycle is ignored.
  3. pc_overwrite:
     - pc <= overwrite_data, state FLUSH.
     - If is_call is also asserted, push pc_mux+1 (mod 2^PC_WIDTH).
     - If the stack is full, the push is not performed: stack_overflow <= 1, state HALTED, PC holds.
  4. Advance: in RUN only, when fetch_valid && fetch_ready, pc <= pc+1. 8'hFF wraps to 8'h00 with no flag.
  5. Otherwise hold: RUN with fetch_ready=0 keeps pc; FLUSH with no new redirect -> RUN with pc unchanged.
- is_call without pc_overwrite is ignored.
- FLUSH is exactly one bubble cycle (fetch_valid=0). A redirect during FLUSH is taken and the block stays in FLUSH one more cycle.
- HALTED:
  - pc and stack are frozen; redirect, call and return inputs are ignored.
  - resume=1 with both error flags 0 -> RUN the next cycle at the held pc.
  - halt and resume asserted together: halt wins (remain HALTED).
- Stack:
  - LIFO register array with a pointer.
  - Push writes entry[stack_count] and increments the count.
  - Pop reads entry[stack_count-1] and decrements the count.
  - A redirect is visible on pc_mux the cycle after it is asserted.
- Latency: input to pc_mux change is 1 cycle. No combinational path from any input to any output.
- A reset asserted mid-operation immediately forces the reset values, including from HALTED or FLUSH.

Test Plan:
- Reset, then fetch_ready=1 held -> cycle 1 BOOT (fetch_valid=0, pc=00); pc_mux then steps 00,01,02,... Preload pc=FE via jump -> sequence FE,FF,00 (wraps).
- Stall: RUN at pc=10, fetch_ready=0 for 3 cycles -> pc stays 10, fetch_valid=1 throughout; on fetch_ready=1 -> 11 next cycle.
- Jump: pc_overwrite=1 with overwrite_data=0x40 at pc=12 -> next cycle pc=40 and FLUSH (fetch_valid=0) -> then RUN at 40, advancing to 41.
- Call/return: at pc=20, call to 0x80 -> stack_count=1. Then at pc=85, return -> pc=21, stack_count=0, one FLUSH bubble between.
- Overflow: 4 nested calls, then a 5th call -> stack_overflow=1, halted=1, pc holds, stack_count=4; resume is ignored; rst_n pulse clears everything.
- Underflow and halt:
  - Return with empty stack -> stack_underflow=1, HALTED.
  - Separately: halt and pc_overwrite in the same cycle -> HALTED and the target is not loaded; resume -> RUN at the held pc the next cycle.
